// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 UART transmitter with a valid/ready byte input.
// The bit period is CLOCK_FREQ / BAUD_RATE clock cycles.
module uart_transmitter #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [7:0] data_in,
  input  logic       ctrl_valid_in,
  output logic       ctrl_ready_out,
  output logic       serial_out
);

  localparam int               BIT_PERIOD   = CLOCK_FREQ / BAUD_RATE;
  localparam int               CNT_W        = $clog2(BIT_PERIOD);
  localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(BIT_PERIOD - 1);
  localparam logic [3:0]       LAST_BIT_IDX = 4'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             serial_r;
  logic             ready_r;
  logic             bit_done_s;

  // Last cycle of the current bit period.
  assign bit_done_s = (cnt_r == CNT_LAST);

  // Frame sequencer; the line and the ready flag are driven straight from registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      bit_idx_r <= 4'd0;
      shift_r   <= 8'h00;
      serial_r  <= 1'b1;
      ready_r   <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r     <= CNT_ZERO;
          bit_idx_r <= 4'd0;
          if (ctrl_valid_in && ready_r) begin
            state_r  <= START;
            shift_r  <= data_in;
            serial_r <= 1'b0;
            ready_r  <= 1'b0;
          end else begin
            serial_r <= 1'b1;
            ready_r  <= 1'b1;
          end
        end
        START: begin
          if (bit_done_s) begin
            state_r  <= DATA;
            cnt_r    <= CNT_ZERO;
            serial_r <= shift_r[0];
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DATA: begin
          if (bit_done_s) begin
            cnt_r <= CNT_ZERO;
            if (bit_idx_r == LAST_BIT_IDX) begin
              state_r   <= STOP;
              bit_idx_r <= 4'd0;
              serial_r  <= 1'b1;
            end else begin
              // Present the next bit while shifting it down into position 0.
              bit_idx_r <= bit_idx_r + 4'd1;
              shift_r   <= {1'b0, shift_r[7:1]};
              serial_r  <= shift_r[1];
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        STOP: begin
          if (bit_done_s) begin
            state_r  <= IDLE;
            cnt_r    <= CNT_ZERO;
            serial_r <= 1'b1;
            ready_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          cnt_r     <= CNT_ZERO;
          bit_idx_r <= 4'd0;
          serial_r  <= 1'b1;
          ready_r   <= 1'b1;
        end
      endcase
    end
  end

  assign ctrl_ready_out = ready_r;
  assign serial_out     = serial_r;

endmodule
